// File: rtl/snake_body.sv
// Snake body store: head position plus a ring of 2-bit link directions,
// game-step update, wall/self collision, and a gapless head-to-tail segment stream.
module snake_body #(
    parameter int GAME_WIDTH  = 18,
    parameter int GAME_HEIGHT = 13,
    parameter int MAX_LEN     = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       game_rst_n,
    input  logic                       step,
    input  logic [1:0]                 step_dir,
    input  logic                       grow,
    output logic [4:0]                 snake_head_x,
    output logic [3:0]                 snake_head_y,
    output logic [4:0]                 snake_x,
    output logic [3:0]                 snake_y,
    output logic [1:0]                 snake_dir,
    output logic                       snake_first,
    output logic                       snake_last,
    output logic                       snake_valid,
    output logic [$clog2(MAX_LEN):0]   length,
    output logic                       full,
    output logic                       self_hit,
    output logic                       wall_hit,
    output logic                       dbg_walk_state
);

    localparam int PW = $clog2(MAX_LEN);
    localparam int LW = PW + 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic [4:0]    INIT_X   = 5'd4;
    localparam logic [3:0]    INIT_Y   = 4'd7;
    localparam logic [LW-1:0] INIT_LEN = LW'(3);
    localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN);
    localparam logic [4:0]    X_BORDER = 5'(GAME_WIDTH + 1);
    localparam logic [3:0]    Y_BORDER = 4'(GAME_HEIGHT + 1);

    function automatic logic [4:0] move_x(input logic [4:0] x, input logic [1:0] d);
        case (d)
            DIR_LEFT:  move_x = x - 5'd1;
            DIR_RIGHT: move_x = x + 5'd1;
            default:   move_x = x;
        endcase
    endfunction

    function automatic logic [3:0] move_y(input logic [3:0] y, input logic [1:0] d);
        case (d)
            DIR_UP:   move_y = y - 4'd1;
            DIR_DOWN: move_y = y + 4'd1;
            default:  move_y = y;
        endcase
    endfunction

    // Game state
    logic [4:0]    head_x_q, head_x_d;
    logic [3:0]    head_y_q, head_y_d;
    logic [PW-1:0] hptr_q, hptr_d;
    logic [LW-1:0] len_q, len_d;
    logic [1:0]    link_q [MAX_LEN];
    logic [1:0]    link_d [MAX_LEN];
    logic          wall_hit_q, wall_hit_d;
    logic          self_hit_q, self_hit_d;

    // Walker state
    logic [0:0]    state_q, state_d;
    logic          start_q, start_d;
    logic [PW-1:0] idx_q, idx_d;
    logic [4:0]    wx_q, wx_d;
    logic [3:0]    wy_q, wy_d;
    logic          acc_q, acc_d;

    // Registered stream beat
    logic          sv_q, sv_d;
    logic          sf_q, sf_d;
    logic          sl_q, sl_d;
    logic [1:0]    sd_q, sd_d;
    logic [4:0]    sx_q, sx_d;
    logic [3:0]    sy_q, sy_d;

    // Step decode: a reversal request keeps the current heading
    logic [1:0]    heading;
    logic [1:0]    eff_dir;
    logic [4:0]    nx;
    logic [3:0]    ny;
    logic          on_border;
    logic          is_full;
    logic [PW-1:0] hptr_dec;

    assign heading   = link_q[hptr_q] ^ 2'b01;
    assign eff_dir   = ((step_dir ^ 2'b01) == heading) ? heading : step_dir;
    assign nx        = move_x(head_x_q, eff_dir);
    assign ny        = move_y(head_y_q, eff_dir);
    assign on_border = (nx == 5'd0) || (nx == X_BORDER) || (ny == 4'd0) || (ny == Y_BORDER);
    assign is_full   = (len_q == LEN_MAX);
    assign hptr_dec  = hptr_q - PW'(1);

    always_comb begin
        head_x_d   = head_x_q;
        head_y_d   = head_y_q;
        hptr_d     = hptr_q;
        len_d      = len_q;
        link_d     = link_q;
        wall_hit_d = wall_hit_q;
        if (!game_rst_n) begin
            head_x_d   = INIT_X;
            head_y_d   = INIT_Y;
            hptr_d     = '0;
            len_d      = INIT_LEN;
            wall_hit_d = 1'b0;
            for (int k = 0; k < MAX_LEN; k++) begin
                link_d[k] = DIR_LEFT;
            end
        end else if (step) begin
            if (on_border) begin
                wall_hit_d = 1'b1;
            end else begin
                hptr_d           = hptr_dec;
                link_d[hptr_dec] = eff_dir ^ 2'b01;
                head_x_d         = nx;
                head_y_d         = ny;
                if (grow && !is_full) begin
                    len_d = len_q + LW'(1);
                end
            end
        end
    end

    // Segment about to be emitted: IDLE always starts from the live head
    logic [PW-1:0] cur_i;
    logic [PW-1:0] cur_ptr;
    logic [4:0]    cur_x;
    logic [3:0]    cur_y;
    logic [1:0]    cur_dir;
    logic          cur_last;
    logic          cur_hit;
    logic          acc_next;
    logic          abort;

    assign cur_i    = (state_q == ST_IDLE) ? '0 : idx_q;
    assign cur_x    = (state_q == ST_IDLE) ? head_x_q : wx_q;
    assign cur_y    = (state_q == ST_IDLE) ? head_y_q : wy_q;
    assign cur_ptr  = hptr_q + cur_i;
    assign cur_dir  = link_q[cur_ptr];
    assign cur_last = ({1'b0, cur_i} == (len_q - LW'(1)));
    assign cur_hit  = (cur_i != '0) && (cur_x == head_x_q) && (cur_y == head_y_q);
    assign acc_next = ((cur_i == '0) ? 1'b0 : acc_q) | cur_hit;
    assign abort    = !game_rst_n || step || !start_q;

    always_comb begin
        state_d    = state_q;
        start_d    = 1'b1;
        idx_d      = idx_q;
        wx_d       = wx_q;
        wy_d       = wy_q;
        acc_d      = acc_q;
        self_hit_d = self_hit_q;
        sv_d       = 1'b0;
        sf_d       = 1'b0;
        sl_d       = 1'b0;
        sd_d       = 2'd0;
        sx_d       = 5'd0;
        sy_d       = 4'd0;
        if (abort) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            acc_d   = 1'b0;
            if (!game_rst_n) begin
                self_hit_d = 1'b0;
            end
        end else begin
            state_d = ST_EMIT;
            sv_d    = 1'b1;
            sf_d    = (cur_i == '0);
            sl_d    = cur_last;
            sd_d    = cur_dir;
            sx_d    = cur_x;
            sy_d    = cur_y;
            acc_d   = acc_next;
            if (cur_last) begin
                // Wrap straight back to the head so the next beat follows with no gap
                idx_d      = '0;
                wx_d       = head_x_q;
                wy_d       = head_y_q;
                self_hit_d = acc_next;
            end else begin
                idx_d = cur_i + PW'(1);
                wx_d  = move_x(cur_x, cur_dir);
                wy_d  = move_y(cur_y, cur_dir);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_x_q   <= INIT_X;
            head_y_q   <= INIT_Y;
            hptr_q     <= '0;
            len_q      <= INIT_LEN;
            wall_hit_q <= 1'b0;
            self_hit_q <= 1'b0;
            for (int k = 0; k < MAX_LEN; k++) begin
                link_q[k] <= DIR_LEFT;
            end
            state_q    <= ST_IDLE;
            start_q    <= 1'b0;
            idx_q      <= '0;
            wx_q       <= INIT_X;
            wy_q       <= INIT_Y;
            acc_q      <= 1'b0;
            sv_q       <= 1'b0;
            sf_q       <= 1'b0;
            sl_q       <= 1'b0;
            sd_q       <= 2'd0;
            sx_q       <= 5'd0;
            sy_q       <= 4'd0;
        end else begin
            head_x_q   <= head_x_d;
            head_y_q   <= head_y_d;
            hptr_q     <= hptr_d;
            len_q      <= len_d;
            wall_hit_q <= wall_hit_d;
            self_hit_q <= self_hit_d;
            link_q     <= link_d;
            state_q    <= state_d;
            start_q    <= start_d;
            idx_q      <= idx_d;
            wx_q       <= wx_d;
            wy_q       <= wy_d;
            acc_q      <= acc_d;
            sv_q       <= sv_d;
            sf_q       <= sf_d;
            sl_q       <= sl_d;
            sd_q       <= sd_d;
            sx_q       <= sx_d;
            sy_q       <= sy_d;
        end
    end

    assign snake_head_x   = head_x_q;
    assign snake_head_y   = head_y_q;
    assign snake_x        = sx_q;
    assign snake_y        = sy_q;
    assign snake_dir      = sd_q;
    assign snake_first    = sf_q;
    assign snake_last     = sl_q;
    assign snake_valid    = sv_q;
    assign length         = len_q;
    assign full           = is_full;
    assign self_hit       = self_hit_q;
    assign wall_hit       = wall_hit_q;
    assign dbg_walk_state = state_q;

endmodule

// File: tb/tb_snake_body.sv
// Directed bench for snake_body: reset stream, move/grow, reversal, wall,
// self-hit, capacity and mid-walk game restart.
module tb_snake_body;

    logic       clk;
    logic       rst_n;
    logic       game_rst_n;
    logic       step;
    logic [1:0] step_dir;
    logic       grow;
    logic [4:0] snake_head_x;
    logic [3:0] snake_head_y;
    logic [4:0] snake_x;
    logic [3:0] snake_y;
    logic [1:0] snake_dir;
    logic       snake_first;
    logic       snake_last;
    logic       snake_valid;
    logic [5:0] length;
    logic       full;
    logic       self_hit;
    logic       wall_hit;
    logic       dbg_walk_state;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected segments {x[8:4], y[3:0]}, head first
    logic [8:0] exp_q[$];
    logic [8:0] body_q[$];

    snake_body #(.GAME_WIDTH(18), .GAME_HEIGHT(13), .MAX_LEN(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .game_rst_n     (game_rst_n),
        .step           (step),
        .step_dir       (step_dir),
        .grow           (grow),
        .snake_head_x   (snake_head_x),
        .snake_head_y   (snake_head_y),
        .snake_x        (snake_x),
        .snake_y        (snake_y),
        .snake_dir      (snake_dir),
        .snake_first    (snake_first),
        .snake_last     (snake_last),
        .snake_valid    (snake_valid),
        .length         (length),
        .full           (full),
        .self_hit       (self_hit),
        .wall_hit       (wall_hit),
        .dbg_walk_state (dbg_walk_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] seg(input int x, input int y);
        seg = {5'(x), 4'(y)};
    endfunction

    function automatic logic [1:0] dir_of(input logic [8:0] a, input logic [8:0] b);
        if (b[8:4] == a[8:4] + 5'd1)      dir_of = 2'd3;
        else if (b[8:4] == a[8:4] - 5'd1) dir_of = 2'd2;
        else if (b[3:0] == a[3:0] + 4'd1) dir_of = 2'd1;
        else                              dir_of = 2'd0;
    endfunction

    task automatic set_exp3(input logic [8:0] a, input logic [8:0] b, input logic [8:0] c);
        exp_q.delete();
        exp_q.push_back(a);
        exp_q.push_back(b);
        exp_q.push_back(c);
    endtask

    task automatic check_head(input string tag, input int x, input int y, input int len);
        check_eq({tag, ".hx"}, snake_head_x, x);
        check_eq({tag, ".hy"}, snake_head_y, y);
        check_eq({tag, ".len"}, length, len);
    endtask

    // Entered at a negedge; checks one full walk against exp_q
    task automatic expect_walk(input string tag, input bit advance);
        int n;
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            if (advance || k > 0) @(negedge clk);
            check_eq({tag, ".valid"}, snake_valid, 1);
            check_eq({tag, ".pos"}, {snake_x, snake_y}, exp_q[k]);
            check_eq({tag, ".first"}, snake_first, (k == 0));
            check_eq({tag, ".last"}, snake_last, (k == n - 1));
            if (k < n - 1) check_eq({tag, ".dir"}, snake_dir, dir_of(exp_q[k], exp_q[k + 1]));
        end
        check_eq({tag, ".wlen"}, length, n);
    endtask

    task automatic wait_head(input string tag);
        int cnt;
        cnt = 0;
        @(negedge clk);
        while (!(snake_valid && snake_first) && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check_eq({tag, ".head_seen"}, snake_valid & snake_first, 1);
    endtask

    task automatic do_step(input logic [1:0] d, input logic g, input string tag);
        step     = 1'b1;
        step_dir = d;
        grow     = g;
        @(negedge clk);
        step = 1'b0;
        grow = 1'b0;
        check_eq({tag, ".bubble"}, snake_valid, 0);
    endtask

    task automatic game_reset(input string tag);
        game_rst_n = 1'b0;
        @(negedge clk);
        check_eq({tag, ".bubble"}, snake_valid, 0);
        game_rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0] loop_dir [4];
        logic [8:0] h;
        loop_dir[0] = 2'd3;
        loop_dir[1] = 2'd0;
        loop_dir[2] = 2'd2;
        loop_dir[3] = 2'd1;

        rst_n      = 1'b0;
        game_rst_n = 1'b1;
        step       = 1'b0;
        step_dir   = 2'd0;
        grow       = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        check_eq("rst.valid", snake_valid, 0);
        check_eq("rst.first", snake_first, 0);
        check_eq("rst.last", snake_last, 0);
        check_eq("rst.dir", snake_dir, 0);
        check_eq("rst.pos", {snake_x, snake_y}, 0);
        check_head("rst", 4, 7, 3);
        check_eq("rst.full", full, 0);
        check_eq("rst.self", self_hit, 0);
        check_eq("rst.wall", wall_hit, 0);

        // Stream starts on the second edge after release, then repeats with no gap
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("start.edge1_valid", snake_valid, 0);
        set_exp3(seg(4, 7), seg(3, 7), seg(2, 7));
        expect_walk("init0", 1'b1);
        check_eq("init0.tail_dir", snake_dir, 2);
        expect_walk("init1", 1'b1);
        check_eq("init1.self", self_hit, 0);

        // Move right, then right with grow, then a reversal request
        do_step(2'd3, 1'b0, "mv");
        check_head("mv", 5, 7, 3);
        set_exp3(seg(5, 7), seg(4, 7), seg(3, 7));
        expect_walk("mv", 1'b1);
        do_step(2'd3, 1'b1, "gr");
        check_head("gr", 6, 7, 4);
        exp_q.push_front(seg(6, 7));
        expect_walk("gr", 1'b1);
        do_step(2'd2, 1'b0, "rev");
        check_head("rev", 7, 7, 4);
        exp_q.push_front(seg(7, 7));
        void'(exp_q.pop_back());
        expect_walk("rev", 1'b1);

        // Wall: six moves up reach row 1, the seventh is refused
        game_reset("wrst");
        for (int i = 0; i < 6; i++) do_step(2'd0, 1'b0, "up");
        check_head("up6", 4, 1, 3);
        check_eq("up6.wall", wall_hit, 0);
        set_exp3(seg(4, 1), seg(4, 2), seg(4, 3));
        expect_walk("up6", 1'b1);
        do_step(2'd0, 1'b1, "wall");
        check_head("wall", 4, 1, 3);
        check_eq("wall.set", wall_hit, 1);
        expect_walk("wall", 1'b1);
        do_step(2'd3, 1'b0, "wallr");
        check_head("wallr", 5, 1, 3);
        check_eq("wallr.sticky", wall_hit, 1);
        game_reset("wclr");
        check_eq("wclr.wall", wall_hit, 0);
        check_head("wclr", 4, 7, 3);

        // Self-hit: grow twice, then up, left, down onto the body
        do_step(2'd3, 1'b1, "sh1");
        do_step(2'd3, 1'b1, "sh2");
        check_head("sh2", 6, 7, 5);
        do_step(2'd0, 1'b0, "sh3");
        exp_q.delete();
        exp_q.push_back(seg(6, 6));
        exp_q.push_back(seg(6, 7));
        exp_q.push_back(seg(5, 7));
        exp_q.push_back(seg(4, 7));
        exp_q.push_back(seg(3, 7));
        expect_walk("sh3", 1'b1);
        check_eq("sh3.self", self_hit, 0);
        do_step(2'd2, 1'b0, "sh4");
        do_step(2'd1, 1'b0, "sh5");
        check_head("sh5", 5, 7, 5);
        exp_q.delete();
        exp_q.push_back(seg(5, 7));
        exp_q.push_back(seg(5, 6));
        exp_q.push_back(seg(6, 6));
        exp_q.push_back(seg(6, 7));
        exp_q.push_back(seg(5, 7));
        expect_walk("sh5", 1'b1);
        check_eq("sh5.self", self_hit, 1);

        // Capacity: grow around a small square loop until full
        game_reset("crst");
        check_eq("crst.self", self_hit, 0);
        body_q.delete();
        body_q.push_back(seg(4, 7));
        body_q.push_back(seg(3, 7));
        body_q.push_back(seg(2, 7));
        for (int i = 0; i < 30; i++) begin
            h = body_q[0];
            case (loop_dir[i % 4])
                2'd0: h[3:0] = h[3:0] - 4'd1;
                2'd1: h[3:0] = h[3:0] + 4'd1;
                2'd2: h[8:4] = h[8:4] - 5'd1;
                default: h[8:4] = h[8:4] + 5'd1;
            endcase
            body_q.push_front(h);
            if (body_q.size() > 32) void'(body_q.pop_back());
            do_step(loop_dir[i % 4], 1'b1, "cap");
            if (i == 27) begin
                check_eq("cap28.len", length, 31);
                check_eq("cap28.full", full, 0);
            end
            if (i == 28) begin
                check_eq("cap29.len", length, 32);
                check_eq("cap29.full", full, 1);
            end
        end
        check_head("cap30", 5, 6, 32);
        check_eq("cap30.full", full, 1);
        exp_q = body_q;
        expect_walk("cap", 1'b1);

        // game_rst_n mid-walk, with a step on the same cycle
        wait_head("mid");
        repeat (2) @(negedge clk);
        game_rst_n = 1'b0;
        step       = 1'b1;
        step_dir   = 2'd1;
        @(negedge clk);
        step       = 1'b0;
        game_rst_n = 1'b1;
        check_eq("mid.bubble", snake_valid, 0);
        check_head("mid", 4, 7, 3);
        check_eq("mid.full", full, 0);
        check_eq("mid.self", self_hit, 0);
        set_exp3(seg(4, 7), seg(3, 7), seg(2, 7));
        expect_walk("mid", 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
